// File: rtl/clz64_pkg.sv
// Shared constants and the nibble-local leading-zero helper for the
// pipelined 64-bit count-leading-zeroes unit.
package clz64_pkg;

  localparam int DATA_W = 64;
  localparam int NIB_N  = 16;
  localparam int GRP_N  = 8;
  localparam int CNT_W  = 7;
  localparam logic [CNT_W-1:0] ZERO_CNT = 7'd64;

  // Leading zeros inside one nibble; an all-zero nibble returns 0 because
  // the zero flag carries that case and the count is ignored there.
  function automatic logic [1:0] nib_lzc(input logic [3:0] nib);
    logic [1:0] cnt;
    cnt = 2'd0;
    if (nib[3])      cnt = 2'd0;
    else if (nib[2]) cnt = 2'd1;
    else if (nib[1]) cnt = 2'd2;
    else if (nib[0]) cnt = 2'd3;
    else             cnt = 2'd0;
    return cnt;
  endfunction

endpackage

// File: rtl/clz64_nibble_lzc4.sv
// One nibble of the stage-1 front end: zero flag plus local leading-zero count.
module nibble_lzc4
  import clz64_pkg::*;
(
  input  logic [3:0] nib,
  output logic       zero,
  output logic [1:0] cnt
);

  // Purely combinational nibble classification
  always_comb begin
    zero = (nib == 4'd0);
    cnt  = nib_lzc(nib);
  end

endmodule

// File: rtl/clz64_pipe.sv
// Two-stage 64-bit count-leading-zeroes pipeline with valid/ready on both
// sides. Stage 1 registers per-nibble zero flags and local counts; stage 2
// priority-encodes the first non-zero nibble in each 8-nibble group and
// registers the final 7-bit count together with the sideband tag.
module clz64_pipe
  import clz64_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              i_CLK,
  input  logic              i_RST_N,
  input  logic              i_VALID,
  output logic              o_READY,
  input  logic [DATA_W-1:0] i_DATA,
  input  logic [TAG_W-1:0]  i_TAG,
  output logic              o_VALID,
  input  logic              i_READY,
  output logic [CNT_W-1:0]  o_COUNT,
  output logic              o_ZERO,
  output logic [TAG_W-1:0]  o_TAG
);

  logic [NIB_N-1:0]      z_comb;
  logic [NIB_N-1:0][1:0] l_comb;

  logic                  v1;
  logic [NIB_N-1:0]      z1;
  logic [NIB_N-1:0][1:0] l1;
  logic [TAG_W-1:0]      tag1;

  logic                  v2;
  logic [CNT_W-1:0]      cnt2;
  logic                  zero2;
  logic [TAG_W-1:0]      tag2;

  logic                  adv2;
  logic                  adv1;

  logic                  hi_found;
  logic                  lo_found;
  logic [2:0]            p_hi;
  logic [2:0]            p_lo;
  logic [CNT_W-1:0]      cnt_next;
  logic                  zero_next;

  // Nibble 0 is the most significant nibble of the operand
  for (genvar k = 0; k < NIB_N; k++) begin : g_nib
    nibble_lzc4 u_nib (
      .nib  (i_DATA[DATA_W-1-4*k -: 4]),
      .zero (z_comb[k]),
      .cnt  (l_comb[k])
    );
  end

  // Each stage moves when its output slot is empty or being drained; the
  // ready path depends only on the valid flags and downstream ready
  always_comb begin
    adv2    = ~v2 | i_READY;
    adv1    = ~v1 | adv2;
    o_READY = adv1;
  end

  // Stage 1: capture nibble flags/counts and tag whenever the stage advances
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      v1   <= 1'b0;
      z1   <= '0;
      l1   <= '0;
      tag1 <= '0;
    end else if (adv1) begin
      v1 <= i_VALID;
      if (i_VALID) begin
        z1   <= z_comb;
        l1   <= l_comb;
        tag1 <= i_TAG;
      end
    end
  end

  // Stage 2 combinational: first non-zero nibble per group, then final mux
  always_comb begin
    hi_found  = 1'b0;
    lo_found  = 1'b0;
    p_hi      = 3'd0;
    p_lo      = 3'd0;
    cnt_next  = ZERO_CNT;
    zero_next = 1'b1;
    for (int k = GRP_N - 1; k >= 0; k--) begin
      if (!z1[k]) begin
        hi_found = 1'b1;
        p_hi     = 3'(k);
      end
      if (!z1[k+GRP_N]) begin
        lo_found = 1'b1;
        p_lo     = 3'(k);
      end
    end
    if (hi_found) begin
      cnt_next  = {1'b0, 1'b0, p_hi, l1[{1'b0, p_hi}]};
      zero_next = 1'b0;
    end else if (lo_found) begin
      cnt_next  = {1'b0, 1'b1, p_lo, l1[{1'b1, p_lo}]};
      zero_next = 1'b0;
    end
  end

  // Stage 2 register: result held stable while downstream stalls
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      v2    <= 1'b0;
      cnt2  <= '0;
      zero2 <= 1'b0;
      tag2  <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        cnt2  <= cnt_next;
        zero2 <= zero_next;
        tag2  <= tag1;
      end
    end
  end

  // Output drive straight from the stage-2 register
  always_comb begin
    o_VALID = v2;
    o_COUNT = cnt2;
    o_ZERO  = zero2;
    o_TAG   = tag2;
  end

endmodule

// File: tb/tb_clz64_pipe.sv
// Self-checking bench for clz64_pipe: directed corner operands, a streaming
// burst, a stall scenario, mid-stream reset and a long randomized run, all
// scored against a bit-scanning reference CLZ.
module tb_clz64_pipe;

  localparam int TAG_W = 4;

  typedef struct {
    logic [6:0]       count;
    logic             zero;
    logic [TAG_W-1:0] tag;
    int               accCycle;
  } expect_t;

  logic              clk;
  logic              rstN;
  logic              inValid;
  logic              inReady;
  logic [63:0]       inData;
  logic [TAG_W-1:0]  inTag;
  logic              outValid;
  logic              outReady;
  logic [6:0]        outCount;
  logic              outZero;
  logic [TAG_W-1:0]  outTag;

  expect_t scoreQ[$];
  int      checks = 0;
  int      errors = 0;
  int      cycle = 0;
  bit      checkLatency = 0;
  int      delivered = 0;

  clz64_pipe #(.TAG_W(TAG_W)) dut (
    .i_CLK   (clk),
    .i_RST_N (rstN),
    .i_VALID (inValid),
    .o_READY (outReady),
    .i_DATA  (inData),
    .i_TAG   (inTag),
    .o_VALID (outValid),
    .i_READY (inReady),
    .o_COUNT (outCount),
    .o_ZERO  (outZero),
    .o_TAG   (outTag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: scan from the MSB down, counting zeros until the first one
  function automatic logic [6:0] refClz(input logic [63:0] d);
    int n;
    n = 0;
    for (int i = 63; i >= 0; i--) begin
      if (d[i]) break;
      n++;
    end
    return 7'(n);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then score the
  // handshakes that will complete on the coming rising edge
  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic [TAG_W-1:0] t,
                               input logic r, input logic [6:0] expCnt, output bit accepted);
    expect_t e;
    @(negedge clk);
    cycle++;
    inValid = v;
    inData  = d;
    inTag   = t;
    inReady = r;
    #1;
    accepted = v && outReady;
    if (outValid && inReady) begin
      if (scoreQ.size() == 0) begin
        checkOutput("unexpected_beat", 64'(outValid), 64'd0);
      end else begin
        e = scoreQ.pop_front();
        checkOutput("count", 64'(outCount), 64'(e.count));
        checkOutput("zero", 64'(outZero), 64'(e.zero));
        checkOutput("tag", 64'(outTag), 64'(e.tag));
        if (checkLatency) checkOutput("latency", 64'(cycle - e.accCycle), 64'd2);
        delivered++;
      end
    end
    if (accepted) begin
      e.count    = expCnt;
      e.zero     = (expCnt == 7'd64);
      e.tag      = t;
      e.accCycle = cycle;
      scoreQ.push_back(e);
    end
  endtask

  // Keep offering one beat until the block takes it, with a cycle bound
  task automatic sendBeat(input logic [63:0] d, input logic [TAG_W-1:0] t, input logic r,
                          input logic [6:0] expCnt);
    bit acc;
    int tries;
    tries = 0;
    acc = 0;
    while (!acc && tries < 50) begin
      applyStimulus(1'b1, d, t, r, expCnt, acc);
      tries++;
    end
    if (!acc) checkOutput("send_timeout", 64'd0, 64'd1);
  endtask

  // Idle cycles with downstream ready until the scoreboard is empty
  task automatic drain();
    bit acc;
    int tries;
    tries = 0;
    while (scoreQ.size() != 0 && tries < 100) begin
      applyStimulus(1'b0, 64'd0, '0, 1'b1, 7'd0, acc);
      tries++;
    end
    checkOutput("drain_left", 64'(scoreQ.size()), 64'd0);
  endtask

  logic [63:0] dirData [6];
  logic [6:0]  dirCnt  [6];

  initial begin
    bit acc;
    logic [63:0] d;
    logic [TAG_W-1:0] t;
    int accCount;
    int budget;

    inValid = 0;
    inReady = 0;
    inData  = '0;
    inTag   = '0;
    rstN    = 0;
    #23;
    checkOutput("rst_valid", 64'(outValid), 64'd0);
    checkOutput("rst_count", 64'(outCount), 64'd0);
    checkOutput("rst_zero", 64'(outZero), 64'd0);
    checkOutput("rst_tag", 64'(outTag), 64'd0);
    @(negedge clk);
    rstN = 1;
    #1;
    checkOutput("rst_ready", 64'(outReady), 64'd1);

    // Directed corner operands with hand-computed counts
    dirData[0] = 64'h8000_0000_0000_0000; dirCnt[0] = 7'd0;
    dirData[1] = 64'h0;                   dirCnt[1] = 7'd64;
    dirData[2] = 64'h1;                   dirCnt[2] = 7'd63;
    dirData[3] = 64'h0000_0001_0000_0000; dirCnt[3] = 7'd31;
    dirData[4] = 64'h0010_0000_0000_0000; dirCnt[4] = 7'd11;
    dirData[5] = 64'h0000_0000_0F00_0000; dirCnt[5] = 7'd36;
    checkLatency = 1;
    for (int i = 0; i < 6; i++) begin
      sendBeat(dirData[i], (i == 0) ? 4'd3 : 4'(i + 8), 1'b1, dirCnt[i]);
      drain();
    end

    // Back-to-back stream of 16 beats, one per cycle, latency two
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom} >> $urandom_range(63, 0);
      applyStimulus(1'b1, d, 4'(i), 1'b1, refClz(d), acc);
      checkOutput("stream_accept", 64'(acc), 64'd1);
    end
    delivered = 0;
    drain();
    checkOutput("stream_delivered", 64'(delivered), 64'd2);
    checkLatency = 0;

    // Stall: downstream not ready while three beats are offered
    delivered = 0;
    d = 64'h0000_0000_0000_0F00;
    sendBeat(d, 4'd1, 1'b0, refClz(d));
    d = 64'h0000_4000_0000_0000;
    sendBeat(d, 4'd2, 1'b0, refClz(d));
    d = 64'h0;
    applyStimulus(1'b1, d, 4'd4, 1'b0, refClz(d), acc);
    checkOutput("stall_ready", 64'(outReady), 64'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, d, 4'd4, 1'b0, refClz(d), acc);
      checkOutput("stall_hold_count", 64'(outCount), 64'(scoreQ[0].count));
      checkOutput("stall_hold_tag", 64'(outTag), 64'(scoreQ[0].tag));
    end
    sendBeat(d, 4'd4, 1'b1, refClz(d));
    drain();
    checkOutput("stall_delivered", 64'(delivered), 64'd3);

    // Reset with both stages full discards everything immediately
    sendBeat(64'h1234, 4'd5, 1'b0, refClz(64'h1234));
    sendBeat(64'h5678, 4'd6, 1'b0, refClz(64'h5678));
    applyStimulus(1'b0, 64'd0, '0, 1'b0, 7'd0, acc);
    checkOutput("full_valid", 64'(outValid), 64'd1);
    #2;
    rstN = 0;
    #1;
    checkOutput("async_rst_valid", 64'(outValid), 64'd0);
    checkOutput("async_rst_count", 64'(outCount), 64'd0);
    scoreQ.delete();
    @(negedge clk);
    rstN = 1;
    #1;
    checkOutput("post_rst_ready", 64'(outReady), 64'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 64'd0, '0, 1'b1, 7'd0, acc);
      checkOutput("no_stale_beat", 64'(outValid), 64'd0);
    end

    // Randomized operands and handshake over 10k accepted beats
    accCount = 0;
    budget = 0;
    while (accCount < 10000 && budget < 60000) begin
      case ($urandom_range(3, 0))
        0: d = 64'd0;
        1: d = 64'd1 << $urandom_range(63, 0);
        default: d = {$urandom, $urandom} >> $urandom_range(63, 0);
      endcase
      t = 4'($urandom);
      applyStimulus($urandom_range(3, 0) != 0, d, t, $urandom_range(3, 0) != 0, refClz(d), acc);
      if (acc) accCount++;
      budget++;
    end
    checkOutput("random_beats", 64'(accCount), 64'd10000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
